// File: rtl/seq_tx_pkg.sv
// ---------------------------------------------------------------------------
// seq_tx_pkg
// Shared definitions for the serial pattern transmitter:
//   - tx_state_t    : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH : default number of bits per transmitted word
// ---------------------------------------------------------------------------
package seq_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pair_counter.sv
// ---------------------------------------------------------------------------
// pair_counter
// Counts how many times the bit on the serial line and the bit sent just
// before it are both 1, i.e. how many adjacent "11" pairs a word contains.
// This equals the number of z pulses the two-consecutive-ones detector
// must produce for that word.
//
// Ports:
//   Clock   in  1   rising-edge clock
//   Resetn  in  1   asynchronous active-low reset
//   curBit  in  1   bit currently on the serial line
//   prevBit in  1   bit sent on the previous cycle (0 before the first bit)
//   clear   in  1   restart the count (word accepted)
//   enable  in  1   a bit is being shifted out on this edge
//   count   out CW  number of 11 pairs seen since the last clear
// ---------------------------------------------------------------------------
module pair_counter #(
    parameter int CW = 3
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          curBit,
    input  logic          prevBit,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    // Clear wins over counting so a new word always starts from zero.
    // The count never exceeds WIDTH-1, which always fits CW bits, so no
    // saturation is needed.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && curBit && prevBit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter feeding the w input of the two-consecutive-ones
// Mealy detector. A word is captured on a start strobe in IDLE and shifted
// out MSB-first, one bit per clock, followed by a one-cycle done pulse.
//
// Ports:
//   Clock   in  1              rising-edge clock
//   Resetn  in  1              asynchronous active-low reset
//   start   in  1              transmit request, sampled only in IDLE
//   data    in  WIDTH          word to transmit, captured on the accept edge
//   w       out 1              serial bit to the detector
//   busy    out 1              high while the word is being shifted out
//   done    out 1              one-cycle pulse after the last bit
//   exp_z   out $clog2(WIDTH)  expected detector z pulse count for the word
//
// Build option:
//   SEQ_TX_EXPECT_EN  when defined, exp_z is produced by a pair counter;
//                     when undefined, exp_z is tied to 0.
// ---------------------------------------------------------------------------
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data,
    output logic                     w,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] exp_z
);

    localparam int CW = $clog2(WIDTH);
    localparam int IW = $clog2(WIDTH);

    tx_state_t        state;
    logic [WIDTH-1:0] shiftReg;
    logic [IW-1:0]    index;
    logic             busyReg;
    logic             doneReg;
    logic             accept;

    assign accept = (state == ST_IDLE) && start;

    // The serial bit is the shift register MSB. The register is loaded only
    // on acceptance and is shifted once per SHIFT edge, including the last
    // one, so it is all-zero in IDLE and DONE and w is low there without any
    // extra gating.
    assign w    = shiftReg[WIDTH-1];
    assign busy = busyReg;
    assign done = doneReg;

    // Transmit FSM with the shift register, bit index and the registered
    // busy/done flags. The index counts down the bits still to send after
    // the current one; SHIFT is left on the edge where it reaches zero.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            index    <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shiftReg <= data;
                        index    <= IW'(WIDTH - 1);
                        busyReg  <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shiftReg <= shiftReg << 1;
                    if (index == '0) begin
                        busyReg <= 1'b0;
                        doneReg <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        index <= index - IW'(1);
                    end
                end
                ST_DONE: begin
                    doneReg <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    shiftReg <= '0;
                    index    <= '0;
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_TX_EXPECT_EN
    logic          prevBit;
    logic [CW-1:0] pairCount;

    // Remembers the bit that was on the line during the previous SHIFT
    // cycle. It restarts at 0 on acceptance because the line is idle-low
    // before the first bit, so the first bit can never complete a pair.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            prevBit <= 1'b0;
        end else if (accept) begin
            prevBit <= 1'b0;
        end else if (state == ST_SHIFT) begin
            prevBit <= shiftReg[WIDTH-1];
        end
    end

    pair_counter #(
        .CW(CW)
    ) u_pair_counter (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .curBit  (shiftReg[WIDTH-1]),
        .prevBit (prevBit),
        .clear   (accept),
        .enable  (state == ST_SHIFT),
        .count   (pairCount)
    );

    assign exp_z = pairCount;
`else
    assign exp_z = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Self-checking bench for seq_pattern_tx (WIDTH = 8). A behavioural model
// turns every accepted word into a list of expected per-cycle outputs; a
// compare process checks the DUT against it on every falling clock edge.
// Directed words with hand-computed results pin the model, then random
// start/data/reset traffic exercises the rest.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

`ifdef SEQ_TX_EXPECT_EN
    localparam bit EXPECT_EN = 1'b1;
`else
    localparam bit EXPECT_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          start;
    logic [W-1:0]  data;
    logic          w;
    logic          busy;
    logic          done;
    logic [CW-1:0] exp_z;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    seq_pattern_tx #(
        .WIDTH(W)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .data   (data),
        .w      (w),
        .busy   (busy),
        .done   (done),
        .exp_z  (exp_z)
    );

    // One expected output set per clock cycle of an active transfer.
    typedef struct {
        logic w;
        logic busy;
        logic done;
        int   expz;
    } exp_t;

    exp_t expQ[$];
    int   heldExp = 0;

    // Number of adjacent 11 pairs among the first n bits sent (MSB first).
    function automatic int pairsInPrefix(input logic [W-1:0] d, input int n);
        int c = 0;
        for (int k = 1; k < n; k++)
            if (d[W-k] && d[W-1-k]) c++;
        return EXPECT_EN ? c : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an empty queue means the transmitter is idle. An
    // idle edge with start=1 schedules W bit cycles plus one done cycle;
    // otherwise each edge consumes one scheduled cycle, so start during
    // a transfer or its done cycle is ignored.
    always @(posedge Clock) begin
        if (Resetn === 1'b1) begin
            if (expQ.size() == 0) begin
                if (start === 1'b1) begin
                    for (int k = 0; k < W; k++)
                        expQ.push_back('{data[W-1-k], 1'b1, 1'b0, pairsInPrefix(data, k)});
                    expQ.push_back('{1'b0, 1'b0, 1'b1, pairsInPrefix(data, W)});
                    heldExp = pairsInPrefix(data, W);
                end
            end else begin
                void'(expQ.pop_front());
            end
        end
    end

    // Reset discards any word in flight and zeroes the held count.
    always @(negedge Resetn) begin
        expQ.delete();
        heldExp = 0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin : cmp
        exp_t e;
        if (expQ.size() != 0) e = expQ[0];
        else                  e = '{1'b0, 1'b0, 1'b0, heldExp};
        checkOutput("w", 32'(w), 32'(e.w));
        checkOutput("busy", 32'(busy), 32'(e.busy));
        checkOutput("done", 32'(done), 32'(e.done));
        checkOutput("exp_z", 32'(exp_z), 32'(e.expz));
    end

    // Requests one word: start is held for exactly one rising edge.
    task automatic applyStimulus(input logic [W-1:0] d);
        @(negedge Clock);
        start = 1'b1;
        data  = d;
        @(negedge Clock);
        start = 1'b0;
        data  = W'($urandom);
    endtask

    // Sends a word and checks the serial pattern, the done pulse and the
    // final count against hand-computed values. With poke set, start is
    // re-asserted mid-transfer and in the done cycle with a different word.
    task automatic runWord(input logic [W-1:0] d, input logic [W-1:0] seqLit,
                           input int zLit, input bit poke, input string tag);
        logic [W-1:0] got;
        applyStimulus(d);
        for (int k = 0; k < W; k++) begin
            got[W-1-k] = w;
            if (poke && k == 3) begin
                start = 1'b1;
                data  = 8'h0F;
            end else begin
                start = 1'b0;
            end
            @(negedge Clock);
        end
        checkOutput({tag, "_wseq"}, 32'(got), 32'(seqLit));
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_expz"}, 32'(exp_z), 32'(EXPECT_EN ? zLit : 0));
        if (poke) begin
            start = 1'b1;
            data  = 8'h0F;
        end
        @(negedge Clock);
        start = 1'b0;
        checkOutput({tag, "_done_clr"}, 32'(done), 32'd0);
        @(negedge Clock);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        start  = 1'b0;
        data   = '0;
        repeat (2) @(negedge Clock);
        checkOutput("reset_w", 32'(w), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_expz", 32'(exp_z), 32'd0);
        #2 Resetn = 1'b1;

        runWord(8'b0110_1110, 8'b0110_1110, 3, 1'b0, "w6E");
        runWord(8'hFF, 8'hFF, 7, 1'b0, "wFF");
        runWord(8'hAA, 8'hAA, 0, 1'b0, "wAA");
        runWord(8'h00, 8'h00, 0, 1'b0, "w00");
        runWord(8'hF0, 8'hF0, 3, 1'b1, "wF0");

        // Abort a transfer with reset between edges after t0+4.
        applyStimulus(8'hFF);
        repeat (3) @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        checkOutput("abort_w", 32'(w), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_expz", 32'(exp_z), 32'd0);
        @(negedge Clock);
        #2 Resetn = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge Clock);
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end
        runWord(8'h03, 8'h03, 1, 1'b0, "w03");

        // Random traffic, including ignored starts and occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge Clock);
            start = ($urandom_range(0, 3) == 0);
            data  = W'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 Resetn = 1'b0;
                @(negedge Clock);
                #2 Resetn = 1'b1;
            end
        end
        @(negedge Clock);
        start = 1'b0;
        repeat (W + 3) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
